// File: rtl/vga_pkg.sv
// Shared timing defaults, derived constants and payload types for the VGA frame sequencer.
`timescale 1ns/1ps
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned CLK_DIV_DEF     = 4;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_BP_DEF        = 48;
  localparam int unsigned H_ACTIVE_DEF    = 640;
  localparam int unsigned H_FP_DEF        = 16;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_BP_DEF        = 33;
  localparam int unsigned V_ACTIVE_DEF    = 480;
  localparam int unsigned V_FP_DEF        = 10;
  localparam int unsigned AUTO_FRAMES_DEF = 60;

  localparam int unsigned H_TOTAL     = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned V_TOTAL     = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned H_ACT_START = H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_ACT_START = V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    MODE_SOLID    = 2'd0,
    MODE_BARS     = 2'd1,
    MODE_CHECKER  = 2'd2,
    MODE_GRADIENT = 2'd3
  } mode_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern generator: pixel position and mode to blanked, channel-masked colour.
`timescale 1ns/1ps
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic       active,
  input  logic [9:0] x,
  input  logic [3:0] y_blk,
  input  mode_t      mode,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  output rgb_t       rgb_c
);

  rgb_t       raw_c;
  logic [2:0] bar_c;
  logic       chk_c;

  assign bar_c = 3'(x / 10'd80);
  assign chk_c = x[5] ^ y_blk[0];

  // Unmasked pattern for the current mode; y_blk carries y[8:5]
  always_comb begin
    raw_c = '0;
    case (mode)
      MODE_SOLID: begin
        raw_c = '1;
      end
      MODE_BARS: begin
        raw_c.r = {4{bar_c[2]}};
        raw_c.g = {4{bar_c[1]}};
        raw_c.b = {4{bar_c[0]}};
      end
      MODE_CHECKER: begin
        raw_c = {12{chk_c}};
      end
      MODE_GRADIENT: begin
        raw_c.r = x[9:6];
        raw_c.g = y_blk;
        raw_c.b = x[9:6] ^ y_blk;
      end
      default: raw_c = '0;
    endcase
  end

  always_comb begin
    rgb_c = '0;
    if (active) begin
      rgb_c.r = raw_c.r & {4{sw1}};
      rgb_c.g = raw_c.g & {4{sw2}};
      rgb_c.b = raw_c.b & {4{sw3}};
    end
  end

endmodule

// File: rtl/vga_frame_sequencer.sv
// 640x480@60 VGA timing, button/auto mode sequencing and registered pin drivers on a pixel-enable tick.
`timescale 1ns/1ps
module vga_frame_sequencer
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_FP        = H_FP_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_FP        = V_FP_DEF,
  parameter int unsigned AUTO_FRAMES = AUTO_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic       sw1,
  input  logic       sw2,
  input  logic       sw3,
  output logic       hsynq,
  output logic       vsynq,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic [1:0] mode,
  output logic       frame_start
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned AF_W   = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int unsigned H_TOT  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOT  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_ACT0 = H_SYNC + H_BP;
  localparam int unsigned V_ACT0 = V_SYNC + V_BP;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [AF_W-1:0]  AF_LAST    = AF_W'(AUTO_FRAMES - 1);
  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_LO   = CNT_W'(H_ACT0);
  localparam logic [CNT_W-1:0] H_ACT_HI   = CNT_W'(H_ACT0 + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LO   = CNT_W'(V_ACT0);
  localparam logic [CNT_W-1:0] V_ACT_HI   = CNT_W'(V_ACT0 + V_ACTIVE);

  localparam logic [1:0] ST_SOLID    = 2'd0;
  localparam logic [1:0] ST_BARS     = 2'd1;
  localparam logic [1:0] ST_CHECKER  = 2'd2;
  localparam logic [1:0] ST_GRADIENT = 2'd3;

  logic [DIV_W-1:0] div_q;
  logic             tick_c;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;
  logic             frame_tick_c;
  logic             btn_s1;
  logic             btn_s2;
  logic             btn_s3;
  logic             btn_edge_c;
  logic             pending_q;
  logic [AF_W-1:0]  frame_cnt_q;
  logic             auto_hit_c;
  logic             advance_c;
  logic [1:0]       state_q;
  logic [1:0]       state_nxt_c;
  logic             active_c;
  logic [9:0]       x_c;
  logic [3:0]       y_blk_c;
  rgb_t             rgb_c;

  // Pixel-enable divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick_c) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  assign tick_c       = (div_q == DIV_LAST);
  assign frame_tick_c = tick_c && (h_q == '0) && (v_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else if (tick_c) begin
      if (h_q == H_LAST) begin
        h_q <= '0;
        v_q <= (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_q <= h_q + CNT_W'(1);
      end
    end
  end

  // Button: two-flop synchronizer, third flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= btn_next;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign btn_edge_c = btn_s2 & ~btn_s3;

  // A press landing on the frame tick survives the clear and is served next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
    end else if (frame_tick_c) begin
      pending_q <= btn_edge_c;
    end else if (btn_edge_c) begin
      pending_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (frame_tick_c) begin
      if (!auto_en || (frame_cnt_q == AF_LAST)) begin
        frame_cnt_q <= '0;
      end else begin
        frame_cnt_q <= frame_cnt_q + AF_W'(1);
      end
    end
  end

  assign auto_hit_c = auto_en && (frame_cnt_q == AF_LAST);
  assign advance_c  = frame_tick_c && (pending_q || auto_hit_c);

  // Mode FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SOLID;
    end else begin
      state_q <= state_nxt_c;
    end
  end

  always_comb begin
    state_nxt_c = state_q;
    if (advance_c) begin
      case (state_q)
        ST_SOLID:    state_nxt_c = ST_BARS;
        ST_BARS:     state_nxt_c = ST_CHECKER;
        ST_CHECKER:  state_nxt_c = ST_GRADIENT;
        ST_GRADIENT: state_nxt_c = ST_SOLID;
        default:     state_nxt_c = ST_SOLID;
      endcase
    end
  end

  assign mode = state_q;

  assign active_c = (h_q >= H_ACT_LO) && (h_q < H_ACT_HI) &&
                    (v_q >= V_ACT_LO) && (v_q < V_ACT_HI);
  assign x_c      = 10'(h_q - H_ACT_LO);
  assign y_blk_c  = 4'((v_q - V_ACT_LO) >> 5);

  vga_pattern_gen u_pattern (
    .active (active_c),
    .x      (x_c),
    .y_blk  (y_blk_c),
    .mode   (mode_t'(state_q)),
    .sw1    (sw1),
    .sw2    (sw2),
    .sw3    (sw3),
    .rgb_c  (rgb_c)
  );

  // Pin registers load from the pre-increment position on each tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsynq       <= 1'b1;
      vsynq       <= 1'b1;
      r           <= '0;
      g           <= '0;
      b           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= frame_tick_c;
      if (tick_c) begin
        hsynq <= (h_q >= H_SYNC_END);
        vsynq <= (v_q >= V_SYNC_END);
        r     <= rgb_c.r;
        g     <= rgb_c.g;
        b     <= rgb_c.b;
      end
    end
  end

endmodule
